// File: rtl/rv32_single_cycle_core.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module   : rv32_single_cycle_core
// Purpose  : Single-cycle RV32I-subset core: PC, decoder, ALU, 32x32 regfile.
//            Executes one instruction per clock from an external ROM and
//            flags EBREAK (stop) and illegal/ALU errors.
// Revision : 1.0 - initial release
// ============================================================================
module rv32_single_cycle_core #(
    parameter int ROM_ADDR_W = 16,
    parameter int RAM_ADDR_W = 16
) (
    input  logic                  clk,
    input  logic                  reset,
    output logic                  stop,
    output logic [1:0]            error,
    input  logic [31:0]           rom_data,
    output logic [ROM_ADDR_W-1:0] rom_address,
    input  logic [31:0]           ram_data,
    output logic [RAM_ADDR_W-1:0] ram_address,
    output logic                  ram_write_enable,
    output logic [31:0]           ram_write_data,
    input  logic [4:0]            dbg_reg_sel,
    output logic [31:0]           dbg_reg_data
);

    localparam logic [6:0]  c_OPC_OP     = 7'b0110011;
    localparam logic [6:0]  c_OPC_OPIMM  = 7'b0010011;
    localparam logic [6:0]  c_OPC_LUI    = 7'b0110111;
    localparam logic [6:0]  c_OPC_JAL    = 7'b1101111;
    localparam logic [6:0]  c_OPC_BRANCH = 7'b1100011;
    localparam logic [31:0] c_EBREAK     = 32'h0010_0073;
    localparam logic [6:0]  c_F7_ZERO    = 7'b0000000;
    localparam logic [6:0]  c_F7_ALT     = 7'b0100000;

    localparam logic [3:0]  c_ALU_ADD  = 4'd0;
    localparam logic [3:0]  c_ALU_SUB  = 4'd1;
    localparam logic [3:0]  c_ALU_AND  = 4'd2;
    localparam logic [3:0]  c_ALU_OR   = 4'd3;
    localparam logic [3:0]  c_ALU_XOR  = 4'd4;
    localparam logic [3:0]  c_ALU_SLL  = 4'd5;
    localparam logic [3:0]  c_ALU_SRL  = 4'd6;
    localparam logic [3:0]  c_ALU_SRA  = 4'd7;
    localparam logic [3:0]  c_ALU_SLT  = 4'd8;
    localparam logic [3:0]  c_ALU_SLTU = 4'd9;

    localparam logic [1:0]  c_WB_ALU  = 2'd0;
    localparam logic [1:0]  c_WB_LUI  = 2'd1;
    localparam logic [1:0]  c_WB_LINK = 2'd2;

    logic [ROM_ADDR_W-1:0] r_pc;
    logic [31:0]           r_regs [32];

    logic [6:0]  w_opcode, w_funct7;
    logic [2:0]  w_funct3;
    logic [4:0]  w_rd, w_rs1, w_rs2;
    logic [31:0] w_imm_i, w_imm_b, w_imm_j, w_imm_u, w_imm_pc;
    logic [31:0] w_rs1_val, w_rs2_val, w_src2, w_alu_res, w_wb_data;
    logic [3:0]  w_alu_op;
    logic [1:0]  w_wb_sel;
    logic        w_illegal, w_reg_we, w_src2_imm, w_is_branch, w_is_jal, w_is_ebreak;
    logic        w_alu_err, w_br_cond, w_taken, w_misaligned, w_commit;
    logic [ROM_ADDR_W-1:0] w_pc_plus4, w_target;
    logic        w_unused_ram;

    assign w_opcode = rom_data[6:0];
    assign w_rd     = rom_data[11:7];
    assign w_funct3 = rom_data[14:12];
    assign w_rs1    = rom_data[19:15];
    assign w_rs2    = rom_data[24:20];
    assign w_funct7 = rom_data[31:25];

    assign w_imm_i = {{20{rom_data[31]}}, rom_data[31:20]};
    assign w_imm_b = {{19{rom_data[31]}}, rom_data[31], rom_data[7], rom_data[30:25], rom_data[11:8], 1'b0};
    assign w_imm_j = {{11{rom_data[31]}}, rom_data[31], rom_data[19:12], rom_data[20], rom_data[30:21], 1'b0};
    assign w_imm_u = {rom_data[31:12], 12'b0};

    // x0 is never written, but reads are forced to zero explicitly as well
    assign w_rs1_val    = (w_rs1 == 5'd0) ? 32'd0 : r_regs[w_rs1];
    assign w_rs2_val    = (w_rs2 == 5'd0) ? 32'd0 : r_regs[w_rs2];
    assign dbg_reg_data = (dbg_reg_sel == 5'd0) ? 32'd0 : r_regs[dbg_reg_sel];

    // Instruction decode: classify the word and pick ALU op / write-back source
    always_comb begin
        w_illegal   = 1'b0;
        w_reg_we    = 1'b0;
        w_src2_imm  = 1'b0;
        w_is_branch = 1'b0;
        w_is_jal    = 1'b0;
        w_is_ebreak = 1'b0;
        w_alu_op    = c_ALU_ADD;
        w_wb_sel    = c_WB_ALU;
        case (w_opcode)
            c_OPC_OP: begin
                w_reg_we = 1'b1;
                if (w_funct7 == c_F7_ZERO) begin
                    case (w_funct3)
                        3'b000:  w_alu_op = c_ALU_ADD;
                        3'b001:  w_alu_op = c_ALU_SLL;
                        3'b010:  w_alu_op = c_ALU_SLT;
                        3'b011:  w_alu_op = c_ALU_SLTU;
                        3'b100:  w_alu_op = c_ALU_XOR;
                        3'b101:  w_alu_op = c_ALU_SRL;
                        3'b110:  w_alu_op = c_ALU_OR;
                        default: w_alu_op = c_ALU_AND;
                    endcase
                end else if (w_funct7 == c_F7_ALT && w_funct3 == 3'b000) begin
                    w_alu_op = c_ALU_SUB;
                end else if (w_funct7 == c_F7_ALT && w_funct3 == 3'b101) begin
                    w_alu_op = c_ALU_SRA;
                end else begin
                    w_illegal = 1'b1;
                end
            end
            c_OPC_OPIMM: begin
                w_reg_we   = 1'b1;
                w_src2_imm = 1'b1;
                case (w_funct3)
                    3'b000: w_alu_op = c_ALU_ADD;
                    3'b010: w_alu_op = c_ALU_SLT;
                    3'b011: w_alu_op = c_ALU_SLTU;
                    3'b100: w_alu_op = c_ALU_XOR;
                    3'b110: w_alu_op = c_ALU_OR;
                    3'b111: w_alu_op = c_ALU_AND;
                    // funct7 field also holds shamt[5], which must be zero on RV32
                    3'b001: begin
                        if (w_funct7 == c_F7_ZERO) w_alu_op = c_ALU_SLL;
                        else                       w_illegal = 1'b1;
                    end
                    default: begin
                        if (w_funct7 == c_F7_ZERO)     w_alu_op = c_ALU_SRL;
                        else if (w_funct7 == c_F7_ALT) w_alu_op = c_ALU_SRA;
                        else                           w_illegal = 1'b1;
                    end
                endcase
            end
            c_OPC_LUI: begin
                w_reg_we = 1'b1;
                w_wb_sel = c_WB_LUI;
            end
            c_OPC_JAL: begin
                w_reg_we = 1'b1;
                w_wb_sel = c_WB_LINK;
                w_is_jal = 1'b1;
            end
            c_OPC_BRANCH: begin
                w_is_branch = 1'b1;
                if (w_funct3 == 3'b010 || w_funct3 == 3'b011) w_illegal = 1'b1;
            end
            default: begin
                if (rom_data == c_EBREAK) w_is_ebreak = 1'b1;
                else                      w_illegal   = 1'b1;
            end
        endcase
    end

    assign w_src2 = w_src2_imm ? w_imm_i : w_rs2_val;

    // ALU: 32-bit modulo arithmetic, shifts use the low five bits of src2
    always_comb begin
        w_alu_err = 1'b0;
        w_alu_res = 32'd0;
        case (w_alu_op)
            c_ALU_ADD:  w_alu_res = w_rs1_val + w_src2;
            c_ALU_SUB:  w_alu_res = w_rs1_val - w_src2;
            c_ALU_AND:  w_alu_res = w_rs1_val & w_src2;
            c_ALU_OR:   w_alu_res = w_rs1_val | w_src2;
            c_ALU_XOR:  w_alu_res = w_rs1_val ^ w_src2;
            c_ALU_SLL:  w_alu_res = w_rs1_val << w_src2[4:0];
            c_ALU_SRL:  w_alu_res = w_rs1_val >> w_src2[4:0];
            c_ALU_SRA:  w_alu_res = $signed(w_rs1_val) >>> w_src2[4:0];
            c_ALU_SLT:  w_alu_res = {31'd0, $signed(w_rs1_val) < $signed(w_src2)};
            c_ALU_SLTU: w_alu_res = {31'd0, w_rs1_val < w_src2};
            default:    w_alu_err = 1'b1;
        endcase
    end

    // Branch condition evaluation on rs1 versus rs2
    always_comb begin
        w_br_cond = 1'b0;
        case (w_funct3)
            3'b000:  w_br_cond = (w_rs1_val == w_rs2_val);
            3'b001:  w_br_cond = (w_rs1_val != w_rs2_val);
            3'b100:  w_br_cond = ($signed(w_rs1_val) <  $signed(w_rs2_val));
            3'b101:  w_br_cond = ($signed(w_rs1_val) >= $signed(w_rs2_val));
            3'b110:  w_br_cond = (w_rs1_val <  w_rs2_val);
            3'b111:  w_br_cond = (w_rs1_val >= w_rs2_val);
            default: w_br_cond = 1'b0;
        endcase
    end

    // PC arithmetic is ROM_ADDR_W wide so it wraps at the top of ROM space
    assign w_imm_pc     = w_is_jal ? w_imm_j : w_imm_b;
    assign w_pc_plus4   = r_pc + ROM_ADDR_W'(4);
    assign w_target     = r_pc + w_imm_pc[ROM_ADDR_W-1:0];
    assign w_taken      = (w_is_branch & w_br_cond) | w_is_jal;
    assign w_misaligned = w_taken & (w_target[1:0] != 2'b00);

    // Status is masked during reset because the ROM may present garbage then
    assign stop     = reset & w_is_ebreak;
    assign error    = {reset & (w_illegal | w_misaligned), reset & w_alu_err};
    assign w_commit = (error == 2'b00) & ~stop;

    // Write-back source selection
    always_comb begin
        w_wb_data = w_alu_res;
        case (w_wb_sel)
            c_WB_LUI:  w_wb_data = w_imm_u;
            c_WB_LINK: w_wb_data = 32'(w_pc_plus4);
            default:   w_wb_data = w_alu_res;
        endcase
    end

    // Program counter: advances only when the instruction commits
    always_ff @(posedge clk or negedge reset) begin
        if (!reset)        r_pc <= '0;
        else if (w_commit) r_pc <= w_taken ? w_target : w_pc_plus4;
    end

    // Register file write-back; x0 writes are dropped
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < 32; i++) r_regs[i] <= 32'd0;
        end else if (w_commit && w_reg_we && w_rd != 5'd0) begin
            r_regs[w_rd] <= w_wb_data;
        end
    end

    assign rom_address      = r_pc;
    assign ram_address      = '0;
    assign ram_write_enable = 1'b0;
    assign ram_write_data   = 32'd0;
    assign w_unused_ram     = ^ram_data;

endmodule
`default_nettype wire

// File: tb/tb_rv32_single_cycle_core.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module   : tb_rv32_single_cycle_core
// Purpose  : Directed self-checking bench for rv32_single_cycle_core with a
//            ROM model and an expected-value scoreboard queue.
// Revision : 1.0 - initial release
// ============================================================================
module tb_rv32_single_cycle_core;

    logic        clk;
    logic        reset;
    logic        stop;
    logic [1:0]  error;
    logic [31:0] rom_data;
    logic [15:0] rom_address;
    logic [31:0] ram_data;
    logic [15:0] ram_address;
    logic        ram_write_enable;
    logic [31:0] ram_write_data;
    logic [4:0]  dbg_reg_sel;
    logic [31:0] dbg_reg_data;

    localparam logic [31:0] NOP    = 32'h0000_0013;
    localparam logic [31:0] EBREAK = 32'h0010_0073;

    logic [31:0] rom [16384];
    logic [31:0] exp_regs [32];
    int          pc_w;
    int          n_cmp;
    int          n_mis;
    bit          mon_en;
    bit          err_seen;

    typedef struct {
        string       tag;
        logic [31:0] val;
    } exp_t;
    exp_t sb_q[$];

    rv32_single_cycle_core #(
        .ROM_ADDR_W(16),
        .RAM_ADDR_W(16)
    ) dut (
        .clk              (clk),
        .reset            (reset),
        .stop             (stop),
        .error            (error),
        .rom_data         (rom_data),
        .rom_address      (rom_address),
        .ram_data         (ram_data),
        .ram_address      (ram_address),
        .ram_write_enable (ram_write_enable),
        .ram_write_data   (ram_write_data),
        .dbg_reg_sel      (dbg_reg_sel),
        .dbg_reg_data     (dbg_reg_data)
    );

    assign rom_data = rom[rom_address[15:2]];

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Any nonzero error seen while a legal program is running is recorded
    always @(negedge clk) begin
        if (mon_en && reset && error !== 2'b00) err_seen = 1'b1;
    end

    function automatic logic [31:0] enc_i(int op, int f3, int rd, int rs1, int imm);
        return {imm[11:0], rs1[4:0], f3[2:0], rd[4:0], op[6:0]};
    endfunction
    function automatic logic [31:0] enc_r(int f7, int f3, int rd, int rs1, int rs2);
        return {f7[6:0], rs2[4:0], rs1[4:0], f3[2:0], rd[4:0], 7'h33};
    endfunction
    function automatic logic [31:0] enc_b(int f3, int rs1, int rs2, int imm);
        return {imm[12], imm[10:5], rs2[4:0], rs1[4:0], f3[2:0], imm[4:1], imm[11], 7'h63};
    endfunction
    function automatic logic [31:0] enc_j(int rd, int imm);
        return {imm[20], imm[10:1], imm[11], imm[19:12], rd[4:0], 7'h6F};
    endfunction
    function automatic logic [31:0] enc_u(int rd, int imm20);
        return {imm20[19:0], rd[4:0], 7'h37};
    endfunction

    task automatic clear_rom();
        for (int i = 0; i < 16384; i++) rom[i] = NOP;
        for (int i = 0; i < 32; i++) exp_regs[i] = 32'd0;
        pc_w = 0;
    endtask

    task automatic put(logic [31:0] w);
        rom[pc_w] = w;
        pc_w++;
    endtask

    task automatic expect_val(string tag, logic [31:0] v);
        exp_t e;
        e.tag = tag;
        e.val = v;
        sb_q.push_back(e);
    endtask

    task automatic observe(logic [31:0] obs);
        exp_t e;
        n_cmp++;
        if (sb_q.size() == 0) begin
            n_mis++;
            $error("FAIL scoreboard_empty observed=%h", obs);
        end else begin
            e = sb_q.pop_front();
            assert (obs === e.val) else begin
                n_mis++;
                $error("FAIL %s observed=%h expected=%h", e.tag, obs, e.val);
            end
        end
    endtask

    task automatic obs_reg(int r);
        @(negedge clk);
        dbg_reg_sel = r[4:0];
        #1;
        observe(dbg_reg_data);
    endtask

    task automatic push_regs(string pfx);
        for (int i = 1; i < 32; i++) expect_val($sformatf("%s_x%0d", pfx, i), exp_regs[i]);
    endtask

    task automatic obs_regs();
        for (int i = 1; i < 32; i++) obs_reg(i);
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset  = 1'b0;
        mon_en = 1'b0;
        @(negedge clk);
        err_seen = 1'b0;
    endtask

    // Release reset and run until stop rises or the cycle budget expires
    task automatic run_to_stop(int max_cycles);
        int n;
        n = 0;
        @(negedge clk);
        reset = 1'b1;
        #1;
        while (!stop && n < max_cycles) begin
            @(negedge clk);
            n++;
        end
    endtask

    task automatic load_main();
        clear_rom();
        put(enc_i(7'h13, 0, 1, 0, 10));
        put(enc_i(7'h13, 0, 1, 1, 50));
        put(enc_i(7'h13, 0, 2, 1, 5));
        put(enc_i(7'h13, 0, 2, 2, -1));
        put(enc_b(1, 2, 1, -4));
        put(enc_b(0, 2, 1, 8));
        put(NOP);
        put(enc_i(7'h13, 0, 3, 2, 1));
        put(enc_i(7'h13, 0, 4, 3, 0));
        put(enc_i(7'h13, 0, 4, 4, 1));
        put(enc_r(7'h20, 0, 5, 4, 1));
        put(enc_j(8, 8));
        put(NOP);
        put(enc_r(0, 7, 6, 1, 2));
        put(enc_i(7'h13, 0, 7, 2, -5));
        put(EBREAK);
        exp_regs[1] = 32'd60; exp_regs[2] = 32'd60; exp_regs[3] = 32'd61;
        exp_regs[4] = 32'd62; exp_regs[5] = 32'd2;  exp_regs[6] = 32'd60;
        exp_regs[7] = 32'd55; exp_regs[8] = 32'd48;
    endtask

    initial begin
        n_cmp = 0; n_mis = 0; mon_en = 1'b0; err_seen = 1'b0;
        reset = 1'b0; ram_data = 32'd0; dbg_reg_sel = 5'd0;
        clear_rom();
        rom[0] = EBREAK;

        // Reset state: outputs quiet even with EBREAK at address 0
        expect_val("rst_pc", 32'd0);
        expect_val("rst_stop", 32'd0);
        expect_val("rst_error", 32'd0);
        expect_val("rst_ram_addr", 32'd0);
        expect_val("rst_ram_we", 32'd0);
        expect_val("rst_ram_wdata", 32'd0);
        expect_val("rst_x1", 32'd0);
        @(negedge clk);
        observe({16'd0, rom_address});
        observe({31'd0, stop});
        observe({30'd0, error});
        observe({16'd0, ram_address});
        observe({31'd0, ram_write_enable});
        observe(ram_write_data);
        obs_reg(1);

        // Main program
        load_main();
        expect_val("main_stop", 32'd1);
        expect_val("main_stop_pc", 32'd60);
        expect_val("main_err_seen", 32'd0);
        expect_val("main_halt_pc", 32'd60);
        expect_val("main_halt_stop", 32'd1);
        push_regs("main");
        mon_en = 1'b1;
        run_to_stop(200);
        observe({31'd0, stop});
        observe({16'd0, rom_address});
        observe({31'd0, err_seen});
        repeat (3) @(negedge clk);
        observe({16'd0, rom_address});
        observe({31'd0, stop});
        obs_regs();

        // Reset mid-run: takes effect without a clock edge, then full rerun
        do_reset();
        load_main();
        expect_val("mid_pc", 32'd0);
        expect_val("mid_x1", 32'd0);
        expect_val("rerun_stop", 32'd1);
        expect_val("rerun_pc", 32'd60);
        expect_val("rerun_err_seen", 32'd0);
        push_regs("rerun");
        @(negedge clk);
        reset  = 1'b1;
        mon_en = 1'b1;
        repeat (8) @(negedge clk);
        dbg_reg_sel = 5'd1;
        #2 reset = 1'b0;
        #1;
        observe({16'd0, rom_address});
        observe(dbg_reg_data);
        run_to_stop(200);
        observe({31'd0, stop});
        observe({16'd0, rom_address});
        observe({31'd0, err_seen});
        obs_regs();

        // x0 writes are discarded
        do_reset();
        clear_rom();
        put(enc_i(7'h13, 0, 1, 0, 7));
        put(enc_i(7'h13, 0, 0, 0, 5));
        put(enc_r(0, 0, 1, 0, 0));
        put(EBREAK);
        expect_val("x0_stop", 32'd1);
        expect_val("x0_x0", 32'd0);
        expect_val("x0_x1", 32'd0);
        run_to_stop(20);
        observe({31'd0, stop});
        obs_reg(0);
        obs_reg(1);

        // ALU corners and remaining branch types
        do_reset();
        clear_rom();
        put(enc_i(7'h13, 0, 1, 0, -1));             exp_regs[1]  = 32'hFFFF_FFFF;
        put(enc_i(7'h13, 5, 2, 1, 12'h404));        exp_regs[2]  = 32'hFFFF_FFFF;
        put(enc_i(7'h13, 5, 4, 1, 12'h004));        exp_regs[4]  = 32'h0FFF_FFFF;
        put(enc_r(0, 2, 3, 1, 0));                  exp_regs[3]  = 32'd1;
        put(enc_r(0, 3, 5, 1, 0));                  exp_regs[5]  = 32'd0;
        put(enc_u(6, 20'h80000));
        put(enc_i(7'h13, 0, 6, 6, -1));             exp_regs[6]  = 32'h7FFF_FFFF;
        put(enc_i(7'h13, 0, 7, 6, 1));              exp_regs[7]  = 32'h8000_0000;
        put(enc_i(7'h13, 4, 9, 6, -1));             exp_regs[9]  = 32'h8000_0000;
        put(enc_i(7'h13, 6, 10, 0, 12'h555));       exp_regs[10] = 32'h0000_0555;
        put(enc_i(7'h13, 7, 11, 1, 12'h0F0));       exp_regs[11] = 32'h0000_00F0;
        put(enc_i(7'h13, 0, 12, 0, 3));             exp_regs[12] = 32'd3;
        put(enc_r(0, 1, 13, 10, 12));               exp_regs[13] = 32'h0000_2AA8;
        put(enc_i(7'h13, 3, 14, 0, 1));             exp_regs[14] = 32'd1;
        put(enc_i(7'h13, 2, 15, 1, 0));             exp_regs[15] = 32'd1;
        put(enc_r(7'h20, 5, 16, 7, 12));            exp_regs[16] = 32'hF000_0000;
        put(enc_r(0, 5, 17, 7, 12));                exp_regs[17] = 32'h1000_0000;
        put(enc_r(0, 6, 18, 10, 12));               exp_regs[18] = 32'h0000_0557;
        put(enc_r(0, 4, 19, 10, 12));               exp_regs[19] = 32'h0000_0556;
        put(enc_r(0, 0, 20, 6, 6));                 exp_regs[20] = 32'hFFFF_FFFE;
        put(enc_r(0, 7, 8, 10, 12));                exp_regs[8]  = 32'd1;
        put(enc_b(4, 1, 0, 8));
        put(enc_i(7'h13, 0, 21, 0, 1));
        put(enc_b(5, 1, 0, 8));
        put(enc_i(7'h13, 0, 22, 0, 1));             exp_regs[22] = 32'd1;
        put(enc_b(6, 0, 1, 8));
        put(enc_i(7'h13, 0, 23, 0, 1));
        put(enc_b(7, 0, 1, 8));
        put(enc_i(7'h13, 0, 24, 0, 1));             exp_regs[24] = 32'd1;
        put(EBREAK);
        expect_val("alu_stop", 32'd1);
        expect_val("alu_err_seen", 32'd0);
        push_regs("alu");
        mon_en = 1'b1;
        run_to_stop(100);
        observe({31'd0, stop});
        observe({31'd0, err_seen});
        obs_regs();

        // Illegal word: masked during reset, flagged after, PC frozen
        do_reset();
        clear_rom();
        rom[0] = 32'hFFFF_FFFF;
        expect_val("ill_err_in_reset", 32'd0);
        expect_val("ill_err", 32'd2);
        expect_val("ill_stop", 32'd0);
        expect_val("ill_pc_held", 32'd0);
        expect_val("ill_err_held", 32'd2);
        expect_val("ill_x1", 32'd0);
        #1;
        observe({30'd0, error});
        @(negedge clk);
        reset = 1'b1;
        #1;
        observe({30'd0, error});
        observe({31'd0, stop});
        repeat (3) @(negedge clk);
        observe({16'd0, rom_address});
        observe({30'd0, error});
        obs_reg(1);

        // Nonzero shamt[5] is illegal; earlier result kept, target untouched
        do_reset();
        clear_rom();
        put(enc_i(7'h13, 0, 1, 0, 9));
        put(enc_i(7'h13, 1, 2, 1, 12'h021));
        expect_val("shamt_err", 32'd2);
        expect_val("shamt_pc", 32'd4);
        expect_val("shamt_x1", 32'd9);
        expect_val("shamt_x2", 32'd0);
        @(negedge clk);
        reset = 1'b1;
        repeat (3) @(negedge clk);
        observe({30'd0, error});
        observe({16'd0, rom_address});
        obs_reg(1);
        obs_reg(2);

        // Taken branch to a non-word-aligned target
        do_reset();
        clear_rom();
        put(enc_b(0, 0, 0, 6));
        expect_val("misalign_err", 32'd2);
        expect_val("misalign_pc", 32'd0);
        @(negedge clk);
        reset = 1'b1;
        repeat (2) @(negedge clk);
        observe({30'd0, error});
        observe({16'd0, rom_address});

        // JAL backwards from address 0 wraps to the top of ROM space
        do_reset();
        clear_rom();
        put(enc_j(1, -4));
        expect_val("wrap_pc", 32'h0000_FFFC);
        expect_val("wrap_x1", 32'd4);
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        observe({16'd0, rom_address});
        obs_reg(1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/rv32_single_cycle_core.md
# rv32_single_cycle_core

Single-cycle RV32I-subset processor core that fetches from an external instruction ROM and executes one instruction per clock. It contains the program counter, instruction decoder, ALU and a 32×32 register file, and signals halt (`EBREAK`) and error conditions to the surrounding system. The data-RAM port is present for future load/store support and is currently driven inactive.

## Interface
- `ROM_ADDR_W`, 16: width of the ROM byte address.
- `RAM_ADDR_W`, 16: width of the RAM byte address.
- `clk`  in  1  single clock; all state changes on the rising edge.
- `reset`  in  1  one clock; reset is asynchronous and active-low.
- `stop`  out  1  high while the current instruction is `EBREAK`.
- `error`  out  2  {decoder, alu}; bit 1 is illegal instruction, bit 0 is invalid ALU op.
- `rom_data`  in  32  instruction at `rom_address`, combinational.
- `rom_address`  out  ROM_ADDR_W  current PC, byte address.
- `ram_data`  in  32  unused.
- `ram_address`  out  RAM_ADDR_W  tied 0.
- `ram_write_enable`  out  1  tied 0.
- `ram_write_data`  out  32  tied 0.
- `dbg_reg_sel`  in  5  debug register select.
- `dbg_reg_data`  out  32  combinational read of register `dbg_reg_sel`; x0 reads 0.

## Operation
- Supported instructions:
  - OP: ADD, SUB, AND, OR, XOR, SLL, SRL, SRA, SLT, SLTU.
  - OP-IMM: ADDI, ANDI, ORI, XORI, SLTI, SLTIU, SLLI, SRLI, SRAI.
  - LUI.
  - JAL.
  - BEQ, BNE, BLT, BGE, BLTU, BGEU.
  - EBREAK.
- Any other encoding sets `error[1]`. This includes opcode `0`, bad funct3/funct7, and a nonzero shamt[5].
- Immediates are sign-extended to 32 bits:
  - I-type is 12 bits.
  - B-type is 13 bits, with bit 0 = 0.
  - J-type is 21 bits, with bit 0 = 0.
  - U-type is `imm[31:12]` followed by 12 zeros.
- ALU arithmetic is 32-bit modulo 2^32. Shift amount is `src2[4:0]`. SLT compares signed and SLTU unsigned. An undefined ALU op code sets `error[0]`.
- Branches: compare rs1 with rs2. If taken, next PC = PC + imm_B; otherwise PC + 4.
- JAL: rd ← PC + 4 and next PC = PC + imm_J.
- PC arithmetic is truncated to `ROM_ADDR_W` bits, so it wraps at 2^ROM_ADDR_W.
- A taken target whose bits [1:0] ≠ 0 sets `error[1]`.
- x0 is hardwired to 0. Writes to x0 are discarded. NOP is `ADDI x0,x0,0`.
- Halt: while `stop` = 1, the PC holds and no register is written. The core stays halted until reset.
- Error: while `error` ≠ 0, the PC holds and no register is written.
- Both `error` bits are forced to 0 while `reset` is asserted, because the ROM may present 0 during reset.

## Timing
- Fetch, decode, execute and next-PC computation are combinational from `rom_address` and `rom_data`.
- Register write-back and the PC update occur together at the rising edge of `clk`. CPI = 1.
- Register reads are combinational. A value written at edge N is visible to the instruction executing after edge N.
- Reset state: PC = 0 and all registers = 0.
- Outputs during reset:
  - `rom_address` = 0.
  - `stop` and `error` = 0.
  - RAM outputs = 0.
- Reset deassertion mid-program: execution restarts at address 0 with cleared registers.
- Reset is asynchronous; it takes effect immediately, independent of `clk`.
- `stop` and `error` are combinational and change in the same cycle the offending instruction is presented.

## Test plan
- Main program: load ROM with the sequence below from address 0, then deassert reset. Required result:
  - Sequence: `ADDI x1,x0,10`; `ADDI x1,x1,50`; `ADDI x2,x1,5`; `ADDI x2,x2,-1`; `BNE x2,x1,-4`; `BEQ x2,x1,+8`; NOP; `ADDI x3,x2,1`; `ADDI x4,x3,0`; `ADDI x4,x4,1`; `SUB x5,x4,x1`; `JAL x8,+8`; NOP; `AND x6,x1,x2`; `ADDI x7,x2,-5`; `EBREAK`.
  - `stop` goes high at PC = 60.
  - Registers: x1 = 60, x2 = 60, x3 = 61, x4 = 62, x5 = 2, x6 = 60, x7 = 55, x8 = 48.
  - All other registers = 0.
  - `error` stays 0 throughout.
- x0 write: `ADDI x0,x0,5` then `ADD x1,x0,x0` → x1 = 0.
- ALU corners:
  - `x1 = -1` (`0xFFFFFFFF`); SRAI by 4 → `0xFFFFFFFF`; SRLI by 4 → `0x0FFFFFFF`.
  - `SLT x3,x1,x0` → 1; `SLTU x3,x1,x0` → 0.
  - `ADDI` of `0x7FFFFFFF` + 1 → `0x80000000`.
- Illegal instruction: present word `0xFFFFFFFF` after reset → `error` = 2'b10, PC does not advance, registers are unchanged. The same word presented during reset → `error` = 0.
- Reset mid-run: assert reset while the loop is running → PC = 0 and registers = 0 immediately, without a clock edge. After release, the program reruns and produces the same final state as the main program.
- Branch wrap: with `ROM_ADDR_W` = 16, `JAL x1,-4` at PC = 0 → next PC = `0xFFFC` and x1 = 4.
